// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GNT0, GNT1)
//   CTI_*       : Wishbone B3 cycle-type encodings
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive strobe cycles without ack/err and
// fires for one cycle when the count reaches TIMEOUT.
//   clk, rst_n : clock, asynchronous active-low reset
//   stb        : strobe presented to the slave
//   ack, err   : slave responses
//   clr        : synchronous clear (arbiter state change)
//   fire       : one-cycle timeout pulse
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic clr,
  output logic fire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{clk, rst_n, stb, ack, err, clr};
      assign fire     = 1'b0;
    end else begin : g_on
      logic [TW-1:0] r_count;

      // Clearing on fire keeps the pulse to a single cycle; an ack in the
      // cycle before TIMEOUT is reached clears first, so ack wins the race.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_count <= '0;
        else if (clr || !stb || ack || err || fire)
          r_count <= '0;
        else
          r_count <= r_count + 1'b1;
      end

      assign fire = (r_count == TW'(TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave Wishbone B3 arbiter in front of the main RAM.
// m0 = CPU-side interconnect, m1 = debug/loader port. Round-robin grant at
// cycle boundaries, bus held for the whole cyc, watchdog forces err.
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   m0_* / m1_* inputs         : master requests (adr, dat, sel, we, cyc, stb, cti, bte)
//   m0_dat_o/ack_o/err_o, m1_* : master responses (data shared from slave)
//   s_* outputs                : muxed request to the slave
//   s_dat_i, s_ack_i, s_err_i  : slave response
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last_owner;
  logic       w_wd_fire;
  logic       w_wd_clr;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (r_state == GNT0 && !m0_cyc_i)
        r_last_owner <= 1'b0;
      else if (r_state == GNT1 && !m1_cyc_i)
        r_last_owner <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    s_adr_o      = '0;
    s_dat_o      = '0;
    s_sel_o      = '0;
    s_we_o       = 1'b0;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_cti_o      = '0;
    s_bte_o      = '0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          w_state_next = r_last_owner ? GNT0 : GNT1;
        else if (m0_cyc_i)
          w_state_next = GNT0;
        else if (m1_cyc_i)
          w_state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i)
          w_state_next = IDLE;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~w_wd_fire;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = (s_err_i & m0_stb_i) | w_wd_fire;
      end
      GNT1: begin
        if (!m1_cyc_i)
          w_state_next = IDLE;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~w_wd_fire;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = (s_err_i & m1_stb_i) | w_wd_fire;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_wd_clr = (w_state_next != r_state);

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .stb   (s_stb_o),
    .ack   (s_ack_i),
    .err   (s_err_i),
    .clr   (w_wd_clr),
    .fire  (w_wd_fire)
  );

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter (watchdog TIMEOUT=4).
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
  logic [DW-1:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel, m1_sel, s_sel_o;
  logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [2:0]    m0_cti, m1_cti, s_cti_o;
  logic [1:0]    m0_bte, m1_bte, s_bte_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;

  typedef struct {
    logic          mid;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TMO),
    .TW      (8)
  ) dut (
    .wb_clk_i (clk),      .wb_rst_ni (rst_n),
    .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat),   .m0_sel_i (m0_sel),
    .m0_we_i  (m0_we),    .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),
    .m0_cti_i (m0_cti),   .m0_bte_i (m0_bte),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat),   .m1_sel_i (m1_sel),
    .m1_we_i  (m1_we),    .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),
    .m1_cti_i (m1_cti),   .m1_bte_i (m1_bte),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),
    .s_cti_o  (s_cti_o),  .s_bte_o  (s_bte_o),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i)
  );

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h0};
  endfunction

  // Slave read data follows whatever address reaches the slave.
  always_comb s_dat_i = mem_data(s_adr_o);

  task automatic drive_m(input int m, input logic cyc, input logic stb,
                         input logic [AW-1:0] adr, input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_dat = ~adr; m0_cti = cti;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_dat = ~adr; m1_cti = cti;
    end
  endtask

  task automatic push_exp(input logic mid, input logic [AW-1:0] adr);
    exp_t e;
    e.mid  = mid;
    e.data = mem_data(adr);
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string name);
    exp_t e;
    logic [DW-1:0] got;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got ack with data %h", name, m0_dat_o);
    end else begin
      e   = sb.pop_front();
      got = e.mid ? m1_dat_o : m0_dat_o;
      if (got !== e.data) begin
        n_fail++;
        $display("FAIL %s: got data %h expected %h", name, got, e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_m(0, 1'b1, 1'b1, 32'h0000_0040, CTI_CLASSIC);
    drive_m(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
    m0_sel = '1; m1_sel = '1; m0_we = 1'b0; m1_we = 1'b0; m0_bte = '0; m1_bte = '0;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    #12;
    n_checks++;
    if ({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 6'b0 || s_adr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%b adr=%h expected 0",
               {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, s_adr_o);
    end
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    s_ack_i = 1'b0; s_err_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tie();
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 32'h300, CTI_CLASSIC);
    drive_m(1, 1'b1, 1'b1, 32'h400, CTI_CLASSIC);
    push_exp(1'b0, 32'h300);
    #1 n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL tie_latency: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk); #1;
    n_checks++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h300}) begin
      n_fail++; $display("FAIL tie_first_m0: got cyc=%b adr=%h expected 1/300", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1; #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL tie_ack0: got %b expected 10", {m0_ack_o, m1_ack_o}); end
    pop_cmp("tie_data0");
    @(negedge clk);
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, 32'h300, CTI_CLASSIC);
    push_exp(1'b1, 32'h400);
    #1 n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL tie_release_comb: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk); #1;
    n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL tie_idle_gap: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk); #1;
    n_checks++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h400}) begin
      n_fail++; $display("FAIL tie_then_m1: got cyc=%b adr=%h expected 1/400", s_cyc_o, s_adr_o);
    end
    s_ack_i = 1'b1; #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b01) begin n_fail++; $display("FAIL tie_ack1: got %b expected 01", {m0_ack_o, m1_ack_o}); end
    pop_cmp("tie_data1");
    @(negedge clk);
    s_ack_i = 1'b0;
    drive_m(1, 1'b0, 1'b0, 32'h400, CTI_CLASSIC);
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 32'h310, CTI_CLASSIC);
    drive_m(1, 1'b1, 1'b1, 32'h410, CTI_CLASSIC);
    @(negedge clk); #1;
    n_checks++;
    if (s_adr_o !== 32'h310) begin n_fail++; $display("FAIL tie_second_m0: got adr %h expected 310", s_adr_o); end
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    @(negedge clk); @(negedge clk);
    drive_m(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_single_read();
    drive_m(0, 1'b1, 1'b1, 32'h100, CTI_CLASSIC);
    push_exp(1'b0, 32'h100);
    #1 n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk); #1;
    n_checks++;
    if ({s_cyc_o, s_stb_o, m0_ack_o, s_adr_o} !== {3'b110, 32'h100}) begin
      n_fail++; $display("FAIL single_grant: got cyc/stb/ack=%b adr=%h expected 110/100",
                         {s_cyc_o, s_stb_o, m0_ack_o}, s_adr_o);
    end
    @(negedge clk);
    @(negedge clk);
    s_ack_i = 1'b1; #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL single_ack: got %b expected 10", {m0_ack_o, m1_ack_o}); end
    pop_cmp("single_data");
    @(negedge clk);
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    #1 n_checks++;
    if ({s_cyc_o, m0_ack_o} !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b expected 00", {s_cyc_o, m0_ack_o}); end
    @(negedge clk);
  endtask

  task automatic test_burst_lock();
    logic [AW-1:0] a;
    logic [2:0]    c;
    drive_m(1, 1'b1, 1'b1, 32'h200, CTI_INC);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      if (b == 1) drive_m(0, 1'b1, 1'b1, 32'h500, CTI_CLASSIC);
      a = 32'h200 + 32'(4 * b);
      c = (b == 3) ? CTI_EOB : CTI_INC;
      drive_m(1, 1'b1, 1'b1, a, c);
      s_ack_i = 1'b1;
      push_exp(1'b1, a);
      #1 n_checks++;
      if ({m0_ack_o, m1_ack_o, s_adr_o, s_dat_o, s_cti_o} !== {2'b01, a, ~a, c}) begin
        n_fail++; $display("FAIL burst_beat%0d: got ack=%b adr=%h dat=%h cti=%b expected 01/%h/%h/%b",
                           b, {m0_ack_o, m1_ack_o}, s_adr_o, s_dat_o, s_cti_o, a, ~a, c);
      end
      pop_cmp("burst_data");
      @(negedge clk);
    end
    s_ack_i = 1'b0;
    drive_m(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
    push_exp(1'b0, 32'h500);
    #1 n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL burst_release: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk); #1;
    n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL burst_idle_gap: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk);
    s_ack_i = 1'b1; #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o, s_adr_o} !== {2'b10, 32'h500}) begin
      n_fail++; $display("FAIL burst_then_m0: got ack=%b adr=%h expected 10/500", {m0_ack_o, m1_ack_o}, s_adr_o);
    end
    pop_cmp("burst_m0_data");
    @(negedge clk);
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    @(negedge clk);
  endtask

  task automatic test_stb_gap();
    drive_m(0, 1'b1, 1'b1, 32'h180, CTI_CLASSIC);
    s_ack_i = 1'b1; s_err_i = 1'b1;
    #1 n_checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin
      n_fail++; $display("FAIL idle_resp_dropped: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    @(negedge clk);
    drive_m(0, 1'b1, 1'b0, 32'h180, CTI_CLASSIC);
    s_err_i = 1'b0;
    #1 n_checks++;
    if ({s_cyc_o, s_stb_o, m0_ack_o} !== 3'b100) begin
      n_fail++; $display("FAIL gap_ack_dropped: got cyc/stb/ack %b expected 100", {s_cyc_o, s_stb_o, m0_ack_o});
    end
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 32'h184, CTI_CLASSIC);
    s_err_i = 1'b1;
    push_exp(1'b0, 32'h184);
    #1 n_checks++;
    if ({m0_ack_o, m0_err_o} !== 2'b11) begin n_fail++; $display("FAIL ack_err_both: got %b expected 11", {m0_ack_o, m0_err_o}); end
    pop_cmp("gap_data");
    @(negedge clk);
    s_ack_i = 1'b0; s_err_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    drive_m(0, 1'b1, 1'b1, 32'h600, CTI_CLASSIC);
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      #1 n_checks++;
      if ({s_stb_o, m0_err_o, m1_err_o} !== {(i != 5), (i == 5), 1'b0}) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got stb/err0/err1 %b expected %b",
                           i, {s_stb_o, m0_err_o, m1_err_o}, {(i != 5), (i == 5), 1'b0});
      end
      @(negedge clk);
    end
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_async_reset();
    drive_m(1, 1'b1, 1'b1, 32'h700, CTI_INC);
    @(negedge clk);
    s_ack_i = 1'b1;
    #1 n_checks++;
    if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre_ack: got %b expected 1", m1_ack_o); end
    #2 rst_n = 1'b0;
    #1 n_checks++;
    if ({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_adr_o, s_cti_o} !== '0) begin
      n_fail++; $display("FAIL areset_immediate: got ctl=%b adr=%h cti=%b expected 0",
                         {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, s_adr_o, s_cti_o);
    end
    s_ack_i = 1'b0;
    drive_m(0, 1'b1, 1'b1, 32'h800, CTI_CLASSIC);
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1 n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL areset_idle: got s_cyc %b expected 0", s_cyc_o); end
    @(negedge clk); #1;
    n_checks++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h800}) begin
      n_fail++; $display("FAIL areset_tie_m0: got cyc=%b adr=%h expected 1/800", s_cyc_o, s_adr_o);
    end
    drive_m(0, 1'b0, 1'b0, '0, CTI_CLASSIC);
    drive_m(1, 1'b0, 1'b0, '0, CTI_CLASSIC);
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_burst_lock();
    test_stb_gap();
    test_timeout();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master to one-slave Wishbone B3 arbiter placed directly upstream of the main RAM slave (wb_ram) in the orpsoc system.
- m0 carries the CPU-side interconnect; m1 carries the debug/loader port.
- Round-robin arbitration at cycle boundaries, bus lock for the whole cycle (including classic/incrementing bursts), and a watchdog that returns err when the slave never responds.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 255, cycles of stb-without-ack before err is forced; 0 disables the watchdog.
- TW, 8, watchdog counter width; TIMEOUT must be < 2**TW.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- m0_adr_i / m1_adr_i  in  AW  master addresses.
- m0_dat_i / m1_dat_i  in  DW  master write data.
- m0_sel_i / m1_sel_i  in  DW/8  byte selects.
- m0_we_i, m0_cyc_i, m0_stb_i / same for m1  in  1 each  master control.
- m0_cti_i / m1_cti_i  in  3  cycle type.
- m0_bte_i / m1_bte_i  in  2  burst type.
- m0_dat_o / m1_dat_o  out  DW  read data, both driven from s_dat_i.
- m0_ack_o, m0_err_o / same for m1  out  1 each  gated responses.
- s_adr_o  out  AW; s_dat_o  out  DW; s_sel_o  out  DW/8; s_we_o, s_cyc_o, s_stb_o  out  1; s_cti_o  out  3; s_bte_o  out  2  (all slave request outputs).
- s_dat_i  in  DW; s_ack_i, s_err_i  in  1  (slave response).

Behaviour:
- Reset (wb_rst_ni low, async): state=IDLE, last_owner=1 (so m0 wins the first tie), watchdog count=0. All s_* outputs 0; all m*_ack_o/m*_err_o 0.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - only m0_cyc_i high -> GNT0.
  - only m1_cyc_i high -> GNT1.
  - both high -> grant the master that is not last_owner.
  - none high -> stay IDLE.
  - Arbitration latency is 1 cycle; no slave signal is asserted while in IDLE.
- GNTx:
  - s_* request outputs are a combinational mux of master x's inputs.
  - s_cyc_o = mx_cyc_i; s_stb_o = mx_stb_i & ~wd_fire.
  - Non-owner master sees ack=err=0.
- Release: in GNTx, when mx_cyc_i is low -> IDLE and last_owner<=x. s_cyc_o drops the same cycle, combinationally. There is no direct GNT0->GNT1 handover; one IDLE cycle always separates owners.
- Bus lock: grant is held for the whole cyc, regardless of stb gaps or cti (000/001/010/111) and regardless of the other master's requests. Burst termination is the master's job.
- Responses:
  - mx_ack_o = owner_x & s_ack_i & mx_stb_i.
  - mx_err_o = owner_x & ((s_err_i & mx_stb_i) | wd_fire).
  - Slave ack/err arriving while stb is low, or in IDLE, is dropped.
- Watchdog (TIMEOUT>0):
  - Count increments each cycle s_stb_o is high with s_ack_i=0 and s_err_i=0.
  - Count clears on ack, err, stb low, or state change.
  - wd_fire = (count == TIMEOUT); it lasts exactly one cycle, then the count clears.
  - An ack and a timeout arriving in the same cycle: ack wins, because count clears before reaching TIMEOUT.
  - TIMEOUT=0: wd_fire is tied 0.
- Simultaneous s_ack_i and s_err_i: both are forwarded. The master treats err as dominant; the arbiter does not filter.
- A master dropping cyc mid-burst is legal. The slave sees cyc fall on the same cycle; no extra beats are generated.

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, GNT0, GNT1}; CTI constants CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INC=3'b010, CTI_EOB=3'b111.
- One sub-module, wb_arb_watchdog: the counter and fire logic, with inputs stb/ack/err/clr and output fire.

Test Plan:
- m0 single read at 0x100, slave acks 2 cycles after stb -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses 1 cycle with m0_dat_o=slave data; m1_ack_o stays 0.
- m0 and m1 raise cyc in the same cycle out of reset -> m0 is granted first; after m0 drops cyc, 1 IDLE cycle, then GNT1; a further tie grants m0 again.
- m1 runs a 4-beat CTI_INC burst (cti 010,010,010,111) while m0 requests at beat 2 -> all 4 m1 acks complete before m0 is granted.
- TIMEOUT=4, slave never acks -> m0_err_o is high exactly in the 5th stb cycle, and s_stb_o is low that cycle.
- wb_rst_ni pulled low mid-burst (async, between clock edges) -> all s_* and ack/err outputs go to 0 immediately; after release, state=IDLE and m0 wins the next tie.
- Slave asserts s_ack_i while m0_stb_i is low within a held cyc -> m0_ack_o stays 0.
